// File: rtl/reset_seq_pkg.sv
// Shared state encoding, output bundle and default timing constants for the reset sequencer.
// The WDT state is only reachable when RESET_SEQ_WATCHDOG_EN is defined.
package reset_seq_pkg;

    localparam int unsigned LOCK_STABLE_CYCLES_DEF = 1024;
    localparam int unsigned STAGE_GAP_DEF          = 16;
    localparam int unsigned WDT_CYCLES_DEF         = 32'd1 << 24;

    // Counter width able to hold (largest count - 1).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES_DEF, STAGE_GAP_DEF, WDT_CYCLES_DEF);

    typedef enum logic [2:0] {
        HOLD,
        STABLE,
        MEM,
        COPRO,
        RUN,
        WDT
    } seq_state_e;

    typedef struct packed {
        logic mem;
        logic copro;
        logic cpu;
        logic ready;
    } rst_out_t;

    localparam rst_out_t RST_OUT_HOLD = '{mem: 1'b1, copro: 1'b1, cpu: 1'b1, ready: 1'b0};

    // Reset/ready levels presented while the sequencer sits in a given state.
    function automatic rst_out_t decode_outputs(input seq_state_e s);
        rst_out_t o;
        o = RST_OUT_HOLD;
        case (s)
            MEM: begin
                o.mem = 1'b0;
            end
            COPRO, WDT: begin
                o.mem   = 1'b0;
                o.copro = 1'b0;
            end
            RUN: begin
                o.mem   = 1'b0;
                o.copro = 1'b0;
                o.cpu   = 1'b0;
                o.ready = 1'b1;
            end
            default: o = RST_OUT_HOLD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Two-flop synchroniser with synchronous clear for a single asynchronous level.
module reset_seq_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/reset_sequencer.sv
// Holds memory, co-processor and CPU resets until PLL lock is stable, then releases them in order.
// Defining RESET_SEQ_WATCHDOG_EN adds a CPU watchdog (wdt_kick / wdt_fired ports, WDT state).
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
    parameter int unsigned STAGE_GAP          = STAGE_GAP_DEF,
    parameter int unsigned WDT_CYCLES         = WDT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic pll_locked,
`ifdef RESET_SEQ_WATCHDOG_EN
    input  logic wdt_kick,
    output logic wdt_fired,
`endif
    output logic reset_memory,
    output logic reset_copro,
    output logic reset_cpu,
    output logic ready
);

    localparam int unsigned CW = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP, WDT_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WDT_LAST    = CW'(WDT_CYCLES - 1);
`endif

    logic          locked_s;
    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    rst_out_t      out_q, out_d;
`ifdef RESET_SEQ_WATCHDOG_EN
    logic          fired_q, fired_d;
`endif

    reset_seq_sync u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            out_q   <= RST_OUT_HOLD;
`ifdef RESET_SEQ_WATCHDOG_EN
            fired_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
`ifdef RESET_SEQ_WATCHDOG_EN
            fired_q <= fired_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef RESET_SEQ_WATCHDOG_EN
        fired_d = fired_q;
`endif
        unique case (state_q)
            HOLD: begin
                cnt_d = '0;
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                if (cnt_q == STABLE_LAST) begin
                    state_d = MEM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MEM: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = COPRO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COPRO: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
`ifdef RESET_SEQ_WATCHDOG_EN
                if (wdt_kick) begin
                    cnt_d = '0;
                end else if (cnt_q == WDT_LAST) begin
                    state_d = WDT;
                    cnt_d   = '0;
                    fired_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            WDT: begin
`ifdef RESET_SEQ_WATCHDOG_EN
                if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                state_d = HOLD;
                cnt_d   = '0;
`endif
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
        // Lock loss beats every other transition and discards any partial count.
        if ((state_q != HOLD) && !locked_s) begin
            state_d = HOLD;
            cnt_d   = '0;
        end
        out_d = decode_outputs(state_d);
    end

    assign reset_memory = out_q.mem;
    assign reset_copro  = out_q.copro;
    assign reset_cpu    = out_q.cpu;
    assign ready        = out_q.ready;
`ifdef RESET_SEQ_WATCHDOG_EN
    assign wdt_fired    = fired_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a run-length lock model predicts every cycle's outputs.
module tb_reset_sequencer;

    localparam int unsigned L   = 8;
    localparam int unsigned G   = 4;
    localparam int unsigned WDT = 32;
    // Output releases expressed as the lock run length seen two edges earlier.
    localparam int unsigned REL_MEM   = L + 1;
    localparam int unsigned REL_COPRO = L + 1 + G;
    localparam int unsigned REL_CPU   = L + 1 + 2 * G;
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef struct packed {
        logic mem;
        logic copro;
        logic cpu;
        logic ready;
        logic fired;
    } exp_t;

    logic clock;
    logic reset;
    logic pll_locked;
    logic reset_memory;
    logic reset_copro;
    logic reset_cpu;
    logic ready;
    logic fired_w;
`ifdef RESET_SEQ_WATCHDOG_EN
    logic wdt_kick;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int unsigned rl0 = 0, rl1 = 0, rl2 = 0;
    bit          wd_in_wdt = 1'b0;
    int unsigned wd_cnt = 0;
    bit          fired_m = 1'b0;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP          (G),
        .WDT_CYCLES         (WDT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pll_locked   (pll_locked),
`ifdef RESET_SEQ_WATCHDOG_EN
        .wdt_kick     (wdt_kick),
        .wdt_fired    (fired_w),
`endif
        .reset_memory (reset_memory),
        .reset_copro  (reset_copro),
        .reset_cpu    (reset_cpu),
        .ready        (ready)
    );

`ifndef RESET_SEQ_WATCHDOG_EN
    assign fired_w = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle of stimulus; the model predicts the outputs after the coming rising edge.
    task automatic step(input bit rst, input bit lock, input bit kick, input bit glitch);
        exp_t        e;
        int unsigned r;
        @(negedge clock);
        reset      = rst;
        pll_locked = lock;
`ifdef RESET_SEQ_WATCHDOG_EN
        wdt_kick   = kick;
`endif
        if (glitch) begin
            pll_locked = ~lock;
            #2;
            pll_locked = lock;
        end
        if (rst) begin
            rl0 = 0; rl1 = 0; rl2 = 0;
            wd_in_wdt = 1'b0; wd_cnt = 0; fired_m = 1'b0;
        end else begin
            rl2 = rl1;
            rl1 = rl0;
            rl0 = lock ? rl0 + 1 : 0;
        end
        r = rl2;
        if (WD_EN && !rst) begin
            if (r == REL_CPU) begin
                wd_in_wdt = 1'b0;
                wd_cnt    = 0;
            end else if (r > REL_CPU) begin
                if (wd_in_wdt) begin
                    if (wd_cnt == G - 1) begin
                        wd_in_wdt = 1'b0;
                        wd_cnt    = 0;
                    end else begin
                        wd_cnt++;
                    end
                end else if (kick) begin
                    wd_cnt = 0;
                end else if (wd_cnt == WDT - 1) begin
                    wd_in_wdt = 1'b1;
                    wd_cnt    = 0;
                    fired_m   = 1'b1;
                end else begin
                    wd_cnt++;
                end
            end
        end
        e.mem   = (r < REL_MEM);
        e.copro = (r < REL_COPRO);
        e.cpu   = (r < REL_CPU) || wd_in_wdt;
        e.ready = !e.cpu;
        e.fired = fired_m;
        exp_q.push_back(e);
    endtask

    // Monitor: compares each registered output sample against the oldest prediction.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                exp_t a;
                e = exp_q.pop_front();
                a = '{mem: reset_memory, copro: reset_copro, cpu: reset_cpu,
                      ready: ready, fired: fired_w};
                cyc++;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got mem=%b copro=%b cpu=%b ready=%b fired=%b, want mem=%b copro=%b cpu=%b ready=%b fired=%b",
                             cyc, a.mem, a.copro, a.cpu, a.ready, a.fired,
                             e.mem, e.copro, e.cpu, e.ready, e.fired);
                end
            end
        end
    end

    initial begin
        bit lock;
        reset      = 1'b1;
        pll_locked = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
        wdt_kick   = 1'b0;
`endif
        // Power-up and full release sequence.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (25) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Long RUN without kicks, then with a kick every 20 cycles.
        repeat (40) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, (i % 20) == 0, 1'b0);
        // Sub-cycle glitches on the lock input.
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b1);
        // Lock loss in RUN and recovery.
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (25) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Unstable lock: 5 high, 1 low, then high.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Synchronous reset while in COPRO.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (16) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (25) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Reset and lock rise on the same edge.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (22) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Randomised mix of lock drops, resets, kicks and glitches.
        lock = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) lock = ~lock;
            step(($urandom_range(0, 63) == 0), lock, ($urandom_range(0, 9) == 0),
                 lock && ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
